toggle_bank: RTL and testbench
==============================

# toggle_bank

Parametrised bank of independent toggle channels for the DE2 VGA design. It generalises the single toggle flip-flop to N_CH channels, each with its own run-time mode. Modes are manual toggle, free-running blink, retriggerable one-shot pulse, and freeze. It drives cursor blink, attribute flashing and strobe signals in the video pipeline from one clock domain.

## Interface
- N_CH, 4: number of channels, 1..2^CH_W.
- CH_W, 2: width of the channel-select field.
- DIV_W, 16: width of each channel's period register and counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- toggle_en  in  N_CH  per-channel event strobe, sampled on the rising edge.
- sync_clr  in  1  synchronous clear of all channel outputs and counters; configuration is retained.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  CH_W  channel index for the write.
- cfg_mode  in  2  mode for the write: 0 manual, 1 blink, 2 one-shot, 3 freeze.
- cfg_period  in  DIV_W  period value for the write, P.
- o_toggle  out  N_CH  channel outputs, registered.
- o_edge  out  N_CH  registered; high for one cycle when the corresponding o_toggle bit changed on the same edge.

## Operation
- Per-channel state: mode (2 bits), period P (DIV_W bits), counter cnt (DIV_W bits), output bit, edge bit.
- Reset values: mode 0, P 0, cnt 0, o_toggle all 0, o_edge all 0.
- Synchronous priority per channel, highest first: sync_clr, then a config write to this channel, then the mode behaviour.
- sync_clr:
  - every o_toggle bit and every cnt go to 0.
  - mode and P are unchanged.
- Config write (cfg_we=1 and cfg_ch < N_CH):
  - loads mode and P into channel cfg_ch.
  - forces that channel's cnt and output to 0.
  - a toggle_en on that channel in the same cycle is ignored.
  - a write with cfg_ch >= N_CH is ignored entirely.
- Mode 0, manual: if toggle_en[i]=1, output inverts; otherwise it holds. cnt is unused and stays 0.
- Mode 1, blink:
  - if cnt == P: output inverts and cnt goes to 0.
  - otherwise cnt increments by 1.
  - toggle_en is ignored.
  - the half-period is P+1 cycles; P=0 inverts the output every cycle.
- Mode 2, one-shot (retriggerable):
  - if toggle_en=1: output goes to 1 and cnt goes to 0. This also applies while the pulse is active, which restarts it.
  - else, if output=1 and cnt == P: output goes to 0.
  - else, if output=1: cnt increments.
  - the pulse width is exactly P+1 cycles measured from the trigger edge.
  - a new trigger arriving on the cycle the pulse would end keeps the output at 1 and restarts cnt.
- Mode 3, freeze: output and cnt hold; toggle_en is ignored.
- o_edge[i] = (next output != current output), registered on the same edge as o_toggle. It covers every cause, including sync_clr and config writes.
- cnt never exceeds P, so no wrap-around is reachable. A mode change always passes through a config write, which clears cnt.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Latency: an input sampled at edge k is reflected on o_toggle and o_edge immediately after edge k, with one register stage.
- Blink:
  - after a config write at edge k, the first inversion happens at edge k+P+1.
  - inversions then repeat every P+1 edges.
- One-shot: trigger at edge k gives output=1 from edge k through edge k+P; output returns to 0 at edge k+P+1.
- Reset mid-operation: asserting rstn low clears all state immediately, without waiting for clk. After deassertion, operation resumes from the reset values.
- rstn deassertion is synchronised externally; the block contains no reset synchroniser.

## Test plan
- Reset and manual mode:
  - release reset with defaults; all outputs are 0.
  - pulse toggle_en[0] on 3 separate cycles: o_toggle[0] reads 1, 0, 1 with an o_edge[0] pulse on each change.
  - other channels stay 0.
- Blink with P=2 on channel 1: o_toggle[1] inverts every 3 cycles after the write.
  - First inversion is 3 edges after the write.
  - o_edge[1] pulses on each inversion.
- One-shot with P=4 on channel 2:
  - single trigger: output is high for exactly 5 cycles.
  - retrigger at cnt=3: output stays high 5 more cycles from the retrigger.
- Priority:
  - cfg write and toggle_en on channel 0 in the same cycle: output is 0 and the toggle is ignored.
  - sync_clr together with a cfg write: outputs are 0 and the new config is not loaded.
  - cfg_ch=5 with N_CH=4: no state change.
- Freeze and async reset:
  - switch a blinking channel to mode 3: output is forced to 0 and then holds for 20 cycles despite toggle_en.
  - assert rstn mid-blink between clock edges: outputs go to 0 before the next edge.

Source files
------------

// File: rtl/toggle_bank.sv
// toggle_bank: N_CH independent toggle channels. Each channel has its own
// run-time mode: manual toggle, free-running blink, retriggerable one-shot,
// or freeze. o_edge flags every change of o_toggle, whatever caused it.
module toggle_bank #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int DIV_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_CH-1:0]   toggle_en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_period,
  output logic [N_CH-1:0]   o_toggle,
  output logic [N_CH-1:0]   o_edge
);

  typedef enum logic [1:0] {
    MODE_MANUAL  = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_FREEZE  = 2'd3
  } mode_e;

  // One extra bit so that N_CH == 2**CH_W still compares correctly.
  localparam logic [CH_W:0] NCH_V = (CH_W+1)'(N_CH);

  mode_e            mode_q   [N_CH];
  logic [DIV_W-1:0] per_q    [N_CH];
  logic [DIV_W-1:0] cnt_q    [N_CH];

  mode_e            mode_nxt [N_CH];
  logic [DIV_W-1:0] per_nxt  [N_CH];
  logic [DIV_W-1:0] cnt_nxt  [N_CH];
  logic [N_CH-1:0]  out_nxt;

  logic             wr_ok;

  // Writes addressed past the last channel are dropped entirely.
  assign wr_ok = cfg_we && ({1'b0, cfg_ch} < NCH_V);

  // Per-channel next state: sync_clr beats a config write, which beats the mode.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      mode_nxt[i] = mode_q[i];
      per_nxt[i]  = per_q[i];
      cnt_nxt[i]  = cnt_q[i];
      out_nxt[i]  = o_toggle[i];
      if (sync_clr) begin
        cnt_nxt[i] = '0;
        out_nxt[i] = 1'b0;
      end else if (wr_ok && (cfg_ch == CH_W'(i))) begin
        mode_nxt[i] = mode_e'(cfg_mode);
        per_nxt[i]  = cfg_period;
        cnt_nxt[i]  = '0;
        out_nxt[i]  = 1'b0;
      end else begin
        case (mode_q[i])
          MODE_MANUAL: begin
            if (toggle_en[i]) out_nxt[i] = ~o_toggle[i];
          end
          MODE_BLINK: begin
            // Counting 0..P gives a half-period of P+1 cycles.
            if (cnt_q[i] == per_q[i]) begin
              out_nxt[i] = ~o_toggle[i];
              cnt_nxt[i] = '0;
            end else begin
              cnt_nxt[i] = cnt_q[i] + 1'b1;
            end
          end
          MODE_ONESHOT: begin
            // A trigger always wins, so a retrigger on the final cycle
            // extends the pulse instead of letting it drop.
            if (toggle_en[i]) begin
              out_nxt[i] = 1'b1;
              cnt_nxt[i] = '0;
            end else if (o_toggle[i] && (cnt_q[i] == per_q[i])) begin
              out_nxt[i] = 1'b0;
            end else if (o_toggle[i]) begin
              cnt_nxt[i] = cnt_q[i] + 1'b1;
            end
          end
          default: begin
            // Freeze: hold output and counter.
          end
        endcase
      end
    end
  end

  // State and output registers; o_edge compares next against current output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i] <= MODE_MANUAL;
        per_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
      o_toggle <= '0;
      o_edge   <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i] <= mode_nxt[i];
        per_q[i]  <= per_nxt[i];
        cnt_q[i]  <= cnt_nxt[i];
      end
      o_toggle <= out_nxt;
      o_edge   <= out_nxt ^ o_toggle;
    end
  end

endmodule

// File: tb/tb_toggle_bank.sv
// Testbench for toggle_bank: table-driven vectors for manual mode and the
// priority rules, plus hand-written blink, freeze, one-shot and reset runs.
module tb_toggle_bank;

  localparam int N_CH  = 4;
  localparam int CH_W  = 3;
  localparam int DIV_W = 16;

  logic              clk;
  logic              rstn;
  logic [N_CH-1:0]   toggle_en;
  logic              sync_clr;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [DIV_W-1:0]  cfg_period;
  logic [N_CH-1:0]   o_toggle;
  logic [N_CH-1:0]   o_edge;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  te;
    logic        clr;
    logic        we;
    logic [2:0]  ch;
    logic [1:0]  mode;
    logic [15:0] per;
    logic [3:0]  exp_t;
    logic [3:0]  exp_e;
  } vec_t;

  vec_t tbl [16];

  toggle_bank #(.N_CH(N_CH), .CH_W(CH_W), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .toggle_en  (toggle_en),
    .sync_clr   (sync_clr),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .o_toggle   (o_toggle),
    .o_edge     (o_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] et, input logic [3:0] ee);
    checks++;
    if (o_toggle !== et) begin
      failures++;
      $display("FAIL %s o_toggle got=%b exp=%b", name, o_toggle, et);
    end
    checks++;
    if (o_edge !== ee) begin
      failures++;
      $display("FAIL %s o_edge got=%b exp=%b", name, o_edge, ee);
    end
  endtask

  // Drive one cycle of inputs, clock it, then check just after the edge.
  task automatic cycle(input string name, input logic [3:0] te, input logic clr,
                       input logic we, input logic [2:0] ch, input logic [1:0] mode,
                       input logic [15:0] per, input logic [3:0] et, input logic [3:0] ee);
    toggle_en  = te;
    sync_clr   = clr;
    cfg_we     = we;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = per;
    @(posedge clk);
    #1;
    check(name, et, ee);
  endtask

  task automatic idle(input string name, input logic [3:0] et, input logic [3:0] ee);
    cycle(name, 4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, et, ee);
  endtask

  initial begin
    logic [3:0] t;
    logic [3:0] e;
    checks   = 0;
    failures = 0;
    rstn       = 1'b0;
    toggle_en  = '0;
    sync_clr   = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_mode   = '0;
    cfg_period = '0;

    //            te       clr   we    ch    mode  per    exp_t    exp_e
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0001, 4'b0001};
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0001, 4'b0000};
    tbl[2]  = '{4'b0001, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0000, 4'b0001};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0001, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0001, 4'b0001};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0001, 4'b0000};
    // config write to ch0 with a toggle on ch0: output forced 0, toggle lost
    tbl[6]  = '{4'b0001, 1'b0, 1'b1, 3'd0, 2'd0, 16'd0, 4'b0000, 4'b0001};
    tbl[7]  = '{4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b1000, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b1000, 4'b1000};
    // write to channel 5 (out of range): nothing changes
    tbl[9]  = '{4'b0000, 1'b0, 1'b1, 3'd5, 2'd1, 16'd0, 4'b1000, 4'b0000};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b1000, 4'b0000};
    tbl[11] = '{4'b0010, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b1010, 4'b0010};
    tbl[12] = '{4'b0010, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b1000, 4'b0010};
    // sync_clr with a config write to ch2: outputs cleared, config not loaded
    tbl[13] = '{4'b0000, 1'b1, 1'b1, 3'd2, 2'd1, 16'd0, 4'b0000, 4'b1000};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0000, 4'b0000};
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0000, 4'b0000};

    #12;
    check("reset", 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle("after_reset", 4'b0000, 4'b0000);

    for (int i = 0; i < 16; i++) begin
      cycle($sformatf("vec%0d", i), tbl[i].te, tbl[i].clr, tbl[i].we, tbl[i].ch,
            tbl[i].mode, tbl[i].per, tbl[i].exp_t, tbl[i].exp_e);
    end

    // Blink on ch1, P=2: inversion on every third edge after the write.
    cycle("blink_wr", 4'b0000, 1'b0, 1'b1, 3'd1, 2'd1, 16'd2, 4'b0000, 4'b0000);
    for (int n = 1; n <= 10; n++) begin
      t = {2'b00, 1'((n / 3) % 2), 1'b0};
      e = {2'b00, 1'(n % 3 == 0), 1'b0};
      idle($sformatf("blink%0d", n), t, e);
    end
    // sync_clr drops the output high->low but keeps the blink config.
    cycle("blink_clr", 4'b0000, 1'b1, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0000, 4'b0010);
    for (int m = 1; m <= 4; m++) begin
      t = {2'b00, 1'((m / 3) % 2), 1'b0};
      e = {2'b00, 1'(m % 3 == 0), 1'b0};
      idle($sformatf("blink_post_clr%0d", m), t, e);
    end

    // Freeze the blinking ch1 while high: forced to 0, then holds.
    cycle("freeze_wr", 4'b0000, 1'b0, 1'b1, 3'd1, 2'd3, 16'd2, 4'b0000, 4'b0010);
    for (int n = 1; n <= 20; n++) begin
      cycle($sformatf("freeze%0d", n), 4'b0010, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0,
            4'b0000, 4'b0000);
    end

    // One-shot on ch2, P=4: high for 5 cycles from the trigger edge.
    cycle("os_wr", 4'b0000, 1'b0, 1'b1, 3'd2, 2'd2, 16'd4, 4'b0000, 4'b0000);
    cycle("os_trig", 4'b0100, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0100, 4'b0100);
    for (int j = 1; j <= 6; j++) begin
      t = (j <= 4) ? 4'b0100 : 4'b0000;
      e = (j == 5) ? 4'b0100 : 4'b0000;
      idle($sformatf("os%0d", j), t, e);
    end
    // Retrigger once cnt has reached 3: five more high cycles from there.
    cycle("os_trig2", 4'b0100, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0100, 4'b0100);
    for (int j = 1; j <= 3; j++) idle($sformatf("os_pre%0d", j), 4'b0100, 4'b0000);
    cycle("os_retrig", 4'b0100, 1'b0, 1'b0, 3'd0, 2'd0, 16'd0, 4'b0100, 4'b0000);
    for (int j = 1; j <= 6; j++) begin
      t = (j <= 4) ? 4'b0100 : 4'b0000;
      e = (j == 5) ? 4'b0100 : 4'b0000;
      idle($sformatf("os_rt%0d", j), t, e);
    end

    // Async reset in the middle of a blink, between clock edges.
    cycle("ar_wr", 4'b0000, 1'b0, 1'b1, 3'd1, 2'd1, 16'd2, 4'b0000, 4'b0000);
    for (int n = 1; n <= 4; n++) begin
      t = {2'b00, 1'((n / 3) % 2), 1'b0};
      e = {2'b00, 1'(n % 3 == 0), 1'b0};
      idle($sformatf("ar_blink%0d", n), t, e);
    end
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset", 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    // Mode is back to manual, so ch1 must no longer blink.
    for (int n = 1; n <= 4; n++) idle($sformatf("post_reset%0d", n), 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
